// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: requester and SRAM-side signal bundle for imem_arbiter.
// slave  = arbiter side, master = requesters plus the SRAM model.
interface imem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch requester (read-only)
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  // loader / debug requester (read/write, optional burst lock)
  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  // SRAM port
  logic          mem_cs;
  logic          mem_oe;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  // status
  logic          misalign;

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    input  mem_dout,
    output f_gnt, f_rvalid, f_rdata,
    output l_gnt, l_rvalid, l_rdata,
    output mem_cs, mem_oe, mem_we, mem_addr, mem_din,
    output misalign
  );

  modport master (
    output f_req, f_addr,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    output mem_dout,
    input  f_gnt, f_rvalid, f_rdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  mem_cs, mem_oe, mem_we, mem_addr, mem_din,
    input  misalign
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction SRAM arbiter between CPU fetch and
// the loader/debug port. Grants and SRAM controls are combinational; read
// data returns registered one cycle after the grant.
// Optional: define IMEM_ARB_STATS_EN to add the conflict_cnt output.
module imem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  imem_arbiter_if.slave       bus
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0]         conflict_cnt
`endif
);

  typedef enum logic {REQ_F = 1'b0, REQ_L = 1'b1} req_e;

  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  logic          f_gnt, l_gnt;
  logic          both, lock_hold, any_mis;
  req_e          last_q, last_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d;
  logic          l_gnt_prev_q;
  logic          f_rvalid_q, l_rvalid_q, misalign_q;
  logic [DW-1:0] f_rdata_q, l_rdata_q;

  // Grant selection: lock keeps a bursting loader on, bounded by LOCK_MAX
  // while fetch waits; otherwise round-robin against the last winner.
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    both      = bus.f_req & bus.l_req;
    lock_hold = bus.l_lock & l_gnt_prev_q;
    if (both) begin
      if (lock_hold) begin
        if (lock_cnt_q < LOCK_MAX_C) l_gnt = 1'b1;
        else                         f_gnt = 1'b1;
      end else if (last_q == REQ_L) begin
        f_gnt = 1'b1;
      end else begin
        l_gnt = 1'b1;
      end
    end else if (bus.f_req) begin
      f_gnt = 1'b1;
    end else if (bus.l_req) begin
      l_gnt = 1'b1;
    end
  end

  // Next arbitration state: last winner and locked-grant counter.
  always_comb begin
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (f_gnt)      last_d = REQ_F;
    else if (l_gnt) last_d = REQ_L;
    // Dropping l_lock or serving fetch ends the burst accounting.
    if (f_gnt || !bus.l_lock)
      lock_cnt_d = 8'd0;
    else if (l_gnt && lock_hold && bus.f_req)
      lock_cnt_d = lock_cnt_q + 8'd1;
  end

  // SRAM drive from the winner; all zero when idle.
  always_comb begin
    bus.mem_cs   = 1'b0;
    bus.mem_oe   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    if (f_gnt) begin
      bus.mem_cs   = 1'b1;
      bus.mem_oe   = 1'b1;
      bus.mem_addr = bus.f_addr;
    end else if (l_gnt) begin
      bus.mem_cs   = 1'b1;
      bus.mem_addr = bus.l_addr;
      if (bus.l_we) begin
        bus.mem_we  = 1'b1;
        bus.mem_din = bus.l_wdata;
      end else begin
        bus.mem_oe  = 1'b1;
      end
    end
  end

  // Misaligned accesses are still issued unmodified; only flagged.
  assign any_mis = (f_gnt & (|bus.f_addr[1:0])) | (l_gnt & (|bus.l_addr[1:0]));

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= REQ_L;
      lock_cnt_q   <= 8'd0;
      l_gnt_prev_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      lock_cnt_q   <= lock_cnt_d;
      l_gnt_prev_q <= l_gnt;
    end
  end

  // Read return: capture mem_dout at the grant edge, rvalid for one cycle;
  // rdata holds until that requester's next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt & ~bus.l_we;
      misalign_q <= any_mis;
      if (f_gnt)               f_rdata_q <= bus.mem_dout;
      if (l_gnt && !bus.l_we)  l_rdata_q <= bus.mem_dout;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rdata  = l_rdata_q;
  assign bus.misalign = misalign_q;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] conflict_q;

  // Saturating count of cycles where both requesters contend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             conflict_q <= 16'd0;
    else if (both && conflict_q != 16'hFFFF) conflict_q <= conflict_q + 16'd1;
  end

  assign conflict_cnt = conflict_q;
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Arbitrates single-port access to the instruction SRAM between two requesters: the CPU fetch path (read-only) and the program loader/debug port (read/write). It drives the SRAM cs/oe/we/addr/din controls combinationally from the winning requester. Read data is returned registered, one cycle after grant. It sits between the PC/fetch logic and the sram instance that backs instruction decode.

Parameters:
AW, 32, address width of both requesters and the memory port
DW, 32, data width
LOCK_MAX, 8, maximum consecutive locked loader grants while fetch is pending (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
f_req  input  1  fetch read request; held until f_gnt
f_addr  input  AW  fetch byte address
f_gnt  output  1  fetch granted this cycle
f_rvalid  output  1  fetch read data valid
f_rdata  output  DW  fetch read data
l_req  input  1  loader request; held until l_gnt
l_we  input  1  loader write (1) / read (0)
l_lock  input  1  loader requests to keep ownership for a burst
l_addr  input  AW  loader byte address
l_wdata  input  DW  loader write data
l_gnt  output  1  loader granted this cycle
l_rvalid  output  1  loader read data valid; reads only
l_rdata  output  DW  loader read data
mem_cs  output  1  SRAM chip select
mem_oe  output  1  SRAM output enable
mem_we  output  1  SRAM write enable
mem_addr  output  AW  SRAM address
mem_din  output  DW  SRAM write data
mem_dout  input  DW  SRAM read data, combinational from mem_addr
misalign  output  1  one-cycle pulse: a granted access had addr[1:0] != 0

Behaviour:
- Reset (rst_n low, async): f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0, misalign=0, lock_cnt=0, last=LOADER. With last=LOADER, fetch wins the first contention.
- Grants are combinational from the requests and the registered state. At most one of f_gnt/l_gnt is high per cycle.
- Only one requester asserts req: it is granted in the same cycle.
- Both assert req, no lock: round-robin, with the winner opposite to `last`.
- Lock rule: l_lock=1 and the loader was granted the previous cycle → the loader wins again while lock_cnt < LOCK_MAX.
- lock_cnt increments on each locked loader grant that occurs while f_req=1. At lock_cnt == LOCK_MAX a pending fetch wins once; lock_cnt then clears.
- lock_cnt also clears on any fetch grant or when l_lock=0.
- `last` updates to the granted requester at each grant edge. It holds when there is no grant.
- Memory drive:
  - No grant: mem_cs=0, mem_oe=0, mem_we=0, mem_addr=0, mem_din=0.
  - Fetch grant: cs=1, oe=1, we=0, addr=f_addr.
  - Loader read: cs=1, oe=1, we=0, addr=l_addr.
  - Loader write: cs=1, oe=0, we=1, addr=l_addr, din=l_wdata.
- Latency: a read granted in cycle N samples mem_dout at the edge ending N. The requester's rvalid is high for exactly cycle N+1 with rdata valid. rdata holds its value until the next read for that requester.
- Loader writes produce no rvalid. They complete at the grant edge.
- Back-to-back: a requester may hold req across cycles and receive consecutive grants, one access per cycle, with rvalid pipelined.
- Misaligned: the access is still performed with the full address, unmodified. misalign pulses in N+1.
- Request dropped before grant: nothing happens; no state changes.
- Reset mid-access: rvalid is forced to 0 immediately; the pending read is lost.
- Simultaneous lock expiry and l_lock drop: the l_lock=0 rule wins and normal round-robin applies.

Optional Feature:
IMEM_ARB_STATS_EN
- Defined: adds output conflict_cnt [15:0]. It increments on every cycle with f_req&l_req both high, saturates at 16'hFFFF, and resets to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then f_req=1 only, f_addr=0x10, mem_dout=0xDEADBEEF → f_gnt=1 same cycle, mem_cs/oe=1; next cycle f_rvalid=1, f_rdata=0xDEADBEEF.
- f_req and l_req (read) held together 4 cycles, no lock → grants alternate F,L,F,L; each rvalid follows its grant by one cycle.
- Loader write l_addr=0x40, l_wdata=0x12345678 → mem_we=1, mem_oe=0, mem_din=0x12345678, l_gnt=1; l_rvalid stays 0.
- LOCK_MAX=3: l_lock=1, l_req=1, then f_req=1 continuously → loader gets 3 locked grants after its first, then fetch gets 1, then loader resumes.
- f_addr=0x13 granted → misalign pulses one cycle after grant; access still issued at 0x13.
- rst_n asserted the cycle after a fetch grant → f_rvalid=0 immediately; after release, the first contention is granted to fetch.
